// File: rtl/hwpe_periph_csb_bridge_if.sv
// rtl/hwpe_periph_csb_bridge_if.sv - HWPE peripheral-slave and NVDLA CSB bus interfaces for the bridge

// Cluster peripheral bus: req/gnt request phase, r_valid response phase
interface hwpe_periph_if #(
  parameter int ID_WIDTH = 1
);
  logic                req;
  logic [31:0]         add;
  logic                wen;
  logic [3:0]          be;
  logic [31:0]         data;
  logic [ID_WIDTH-1:0] id;
  logic                gnt;
  logic [31:0]         r_data;
  logic                r_valid;
  logic [ID_WIDTH-1:0] r_id;

  modport master (
    output req, add, wen, be, data, id,
    input  gnt, r_data, r_valid, r_id
  );

  modport slave (
    input  req, add, wen, be, data, id,
    output gnt, r_data, r_valid, r_id
  );
endinterface

// NVDLA CSB port: valid/ready request channel, nvdla2csb response strobes
interface nvdla_csb_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  valid;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdat;
  logic                  write;
  logic                  nposted;
  logic                  rsp_valid;
  logic [31:0]           rsp_data;
  logic                  wr_complete;

  modport master (
    output valid, addr, wdat, write, nposted,
    input  ready, rsp_valid, rsp_data, wr_complete
  );

  modport slave (
    input  valid, addr, wdat, write, nposted,
    output ready, rsp_valid, rsp_data, wr_complete
  );
endinterface

// File: rtl/hwpe_periph_csb_bridge.sv
// rtl/hwpe_periph_csb_bridge.sv - periph-slave to NVDLA CSB bridge, one access in flight, read timeout; HWPE_CSB_NONPOSTED_WR_EN enables non-posted writes

module hwpe_periph_csb_bridge #(
  parameter int unsigned ID_WIDTH       = 1,
  parameter int unsigned CSB_ADDR_WIDTH = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  hwpe_periph_if.slave periph,
  nvdla_csb_if.master  csb
);

  // Counter only needs to reach TIMEOUT_CYCLES-2: WAIT_RD lasts at most TIMEOUT_CYCLES-1 cycles,
  // so the response lands exactly TIMEOUT_CYCLES cycles after the CSB accept.
  localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

`ifdef HWPE_CSB_NONPOSTED_WR_EN
  localparam bit NONPOSTED_WR = 1'b1;
`else
  localparam bit NONPOSTED_WR = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_RD = 3'd2,
    WAIT_WR = 3'd3,
    RESP    = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [CSB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]               wdat_q, wdat_d;
  logic                      write_q, write_d;
  logic [ID_WIDTH-1:0]       id_q, id_d;
  logic [31:0]               rdata_q, rdata_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      gnt;

  // Byte enables and the address bits outside the CSB word range carry no information for CSB
  logic unused_add_be;
  assign unused_add_be = ^{periph.be, periph.add[31:CSB_ADDR_WIDTH+2], periph.add[1:0]};

  // State and latched transaction fields; reset abandons any access in flight
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdat_q  <= '0;
      write_q <= 1'b0;
      id_q    <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      write_q <= write_d;
      id_q    <= id_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and field capture; counter defaults to zero so it clears whenever WAIT_RD is left
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    write_d = write_q;
    id_d    = id_q;
    rdata_d = rdata_q;
    cnt_d   = '0;
    gnt     = 1'b0;

    case (state_q)
      IDLE: begin
        gnt = periph.req;
        if (periph.req) begin
          addr_d  = periph.add[CSB_ADDR_WIDTH+1:2];
          write_d = ~periph.wen;
          wdat_d  = periph.data;
          id_d    = periph.id;
          rdata_d = '0;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        if (csb.ready) begin
          if (!write_q) begin
            state_d = WAIT_RD;
          end else if (NONPOSTED_WR) begin
            state_d = WAIT_WR;
          end else begin
            state_d = RESP;
          end
        end
      end

      WAIT_RD: begin
        // Real data arriving on the expiry cycle takes priority over the timeout pattern
        if (csb.rsp_valid) begin
          rdata_d = csb.rsp_data;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = TIMEOUT_DATA;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WAIT_WR: begin
        if (csb.wr_complete) begin
          state_d = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign periph.gnt     = gnt;
  assign periph.r_valid = (state_q == RESP);
  assign periph.r_data  = rdata_q;
  assign periph.r_id    = id_q;

  assign csb.valid   = (state_q == ISSUE);
  assign csb.addr    = addr_q;
  assign csb.wdat    = wdat_q;
  assign csb.write   = write_q;
  assign csb.nposted = write_q & NONPOSTED_WR;

endmodule

// File: tb/tb_hwpe_periph_csb_bridge.sv
// tb/tb_hwpe_periph_csb_bridge.sv - self-checking bench for hwpe_periph_csb_bridge; honours HWPE_CSB_NONPOSTED_WR_EN

module tb_hwpe_periph_csb_bridge;

  localparam int          ID_W    = 1;
  localparam int          AW      = 16;
  localparam int          TO      = 16;
  localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;
  localparam int          NO_RSP  = 1000;
`ifdef HWPE_CSB_NONPOSTED_WR_EN
  localparam bit NP = 1'b1;
`else
  localparam bit NP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hwpe_periph_if #(.ID_WIDTH(ID_W)) pif ();
  nvdla_csb_if   #(.ADDR_WIDTH(AW)) cif ();

  hwpe_periph_csb_bridge #(
    .ID_WIDTH       (ID_W),
    .CSB_ADDR_WIDTH (AW),
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_DATA   (TO_DATA)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .periph (pif),
    .csb    (cif)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // delay: cycles from CSB accept to the core response (reads, and writes when non-posted)
  typedef struct {
    logic            wen;
    logic [31:0]     add;
    logic [31:0]     data;
    logic [ID_W-1:0] id;
    int              stall;
    int              delay;
    logic [31:0]     rdata;
    logic [AW-1:0]   exp_addr;
    logic [31:0]     exp_rdata;
    int              exp_lat;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic wen, input logic [31:0] add, input logic [31:0] data,
                              input logic [ID_W-1:0] id, input int stall, input int delay,
                              input logic [31:0] rdata, input logic [AW-1:0] exp_addr,
                              input logic [31:0] exp_rdata, input int exp_lat);
    vec_t v;
    v.wen = wen; v.add = add; v.data = data; v.id = id; v.stall = stall; v.delay = delay;
    v.rdata = rdata; v.exp_addr = exp_addr; v.exp_rdata = exp_rdata; v.exp_lat = exp_lat;
    return v;
  endfunction

  // Transaction-level reference: latency measured from the request cycle
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_addr = v.add[AW+1:2];
    if (!v.wen) begin
      r.exp_rdata = 32'h0;
      r.exp_lat   = NP ? 2 + v.stall + v.delay : 2 + v.stall;
    end else if (v.delay <= TO - 1) begin
      r.exp_rdata = v.rdata;
      r.exp_lat   = 2 + v.stall + v.delay;
    end else begin
      r.exp_rdata = TO_DATA;
      r.exp_lat   = 1 + v.stall + TO;
    end
    return r;
  endfunction

  task automatic idle_inputs();
    pif.req = 1'b0; pif.add = '0; pif.wen = 1'b0; pif.be = '0; pif.data = '0; pif.id = '0;
    cif.ready = 1'b0; cif.rsp_valid = 1'b0; cif.rsp_data = '0; cif.wr_complete = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int acc_k = 1 + v.stall;
    int rsp_k = acc_k + v.delay;
    int acc_n = 0, acc_at = -1, rv_n = 0, rv_at = -1, gnt_n = 0, vld_n = 0, bad = 0;
    logic [31:0] rv_data = '0;
    logic [ID_W-1:0] rv_id = '0;
    for (int k = 0; k <= v.exp_lat + 2; k++) begin
      @(posedge clk); #1;
      pif.req  = (k == 0);
      pif.wen  = (k == 0) ? v.wen : 1'($urandom);
      pif.add  = (k == 0) ? v.add : $urandom;
      pif.data = (k == 0) ? v.data : $urandom;
      pif.id   = (k == 0) ? v.id : ID_W'($urandom);
      pif.be   = 4'($urandom);
      cif.ready     = (k >= acc_k);
      cif.rsp_valid = (v.wen && k == rsp_k) || (k == 0 && $urandom_range(0, 1) == 1);
      cif.rsp_data  = (v.wen && k == rsp_k) ? v.rdata : $urandom;
`ifdef HWPE_CSB_NONPOSTED_WR_EN
      cif.wr_complete = !v.wen && k == rsp_k;
`else
      cif.wr_complete = 1'($urandom);
`endif
      #1;
      if (pif.gnt) gnt_n++;
      if (cif.valid) begin
        vld_n++;
        if (cif.addr !== v.exp_addr || cif.wdat !== v.data || cif.write !== !v.wen ||
            cif.nposted !== (NP && !v.wen)) bad++;
        if (cif.ready) begin acc_n++; acc_at = k; end
      end
      if (pif.r_valid) begin rv_n++; rv_at = k; rv_data = pif.r_data; rv_id = pif.r_id; end
    end
    idle_inputs();
    check($sformatf("v%0d gnt_cycles", idx), gnt_n, 1);
    check($sformatf("v%0d valid_cycles", idx), vld_n, v.stall + 1);
    check($sformatf("v%0d csb_fields_bad", idx), bad, 0);
    check($sformatf("v%0d accepts", idx), acc_n, 1);
    check($sformatf("v%0d accept_cycle", idx), acc_at, acc_k);
    check($sformatf("v%0d r_valid_pulses", idx), rv_n, 1);
    check($sformatf("v%0d r_valid_cycle", idx), rv_at, v.exp_lat);
    check($sformatf("v%0d r_data", idx), rv_data, v.exp_rdata);
    check($sformatf("v%0d r_id", idx), rv_id, v.id);
  endtask

  // Request held high across two writes: the second grant waits for the first response
  task automatic hold_test();
    int lat1 = NP ? 3 : 2;
    int gnt2_at = -1, rv1_at = -1, gnt_n = 0;
    bit seen_rv2 = 0, seen_addr2 = 0;
    for (int k = 0; k <= lat1 + 1; k++) begin
      @(posedge clk); #1;
      pif.req = 1'b1; pif.wen = 1'b0; pif.be = 4'hF; pif.id = '0;
      pif.add  = (k == 0) ? 32'h0000_0040 : 32'h0000_0044;
      pif.data = (k == 0) ? 32'h0000_1111 : 32'h0000_2222;
      cif.ready = 1'b1;
      cif.wr_complete = NP && (k == 2);
      #1;
      if (pif.gnt) begin gnt_n++; if (k > 0 && gnt2_at < 0) gnt2_at = k; end
      if (pif.r_valid && rv1_at < 0) rv1_at = k;
    end
    for (int j = 0; j < 20 && !seen_rv2; j++) begin
      @(posedge clk); #1;
      pif.req = 1'b0; cif.ready = 1'b1; cif.wr_complete = NP;
      #1;
      if (cif.valid && cif.addr == 16'h0011) seen_addr2 = 1;
      if (pif.r_valid) seen_rv2 = 1;
    end
    idle_inputs();
    check("hold gnt_count", gnt_n, 2);
    check("hold first_r_valid", rv1_at, lat1);
    check("hold second_gnt", gnt2_at, lat1 + 1);
    check("hold second_addr", seen_addr2, 1);
    check("hold second_r_valid", seen_rv2, 1);
  endtask

  // Reset during WAIT_RD, then stale core responses in IDLE
  task automatic reset_test();
    int rv_n = 0, nz = 0;
    for (int k = 0; k <= 8; k++) begin
      @(posedge clk); #1;
      pif.req = (k == 0); pif.wen = 1'b1; pif.add = 32'h0000_0050; pif.id = 1'b1;
      cif.ready = (k == 1);
      rst_n = (k != 3);
      cif.rsp_valid = (k >= 4);
      cif.rsp_data  = $urandom;
      #1;
      if (pif.r_valid) rv_n++;
      if (k == 4) begin
        check("rst periph_outputs", {pif.gnt, pif.r_valid, pif.r_data, pif.r_id}, '0);
        check("rst csb_outputs", {cif.valid, cif.addr, cif.wdat, cif.write, cif.nposted}, '0);
      end
      if (k > 4 && ({pif.gnt, pif.r_valid, cif.valid, cif.write} != 4'b0 || pif.r_data != 0)) nz++;
    end
    idle_inputs();
    check("rst r_valid_pulses", rv_n, 0);
    check("rst stale_rsp_effects", nz, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset periph_outputs", {pif.gnt, pif.r_valid, pif.r_data, pif.r_id}, '0);
    check("reset csb_outputs", {cif.valid, cif.addr, cif.wdat, cif.write, cif.nposted}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed rows, expectations worked out by hand
    vt.push_back(mk(1'b0, 32'h0000_1004, 32'hCAFE_F00D, 1'b1, 0, 4, 32'h0,
                    16'h0401, 32'h0, NP ? 6 : 2));
    vt.push_back(mk(1'b1, 32'h0000_0008, 32'h0, 1'b1, 0, 5, 32'h1234_5678,
                    16'h0002, 32'h1234_5678, 7));
    vt.push_back(mk(1'b0, 32'h0000_0100, 32'hA5A5_5A5A, 1'b0, 3, 2, 32'h0,
                    16'h0040, 32'h0, NP ? 7 : 5));
    vt.push_back(mk(1'b1, 32'h0000_0020, 32'h0, 1'b0, 0, NO_RSP, 32'h0,
                    16'h0008, 32'hDEAD_BEEF, 17));
    vt.push_back(mk(1'b1, 32'h0000_0024, 32'h0, 1'b0, 0, 3, 32'h0BAD_CAFE,
                    16'h0009, 32'h0BAD_CAFE, 5));
    vt.push_back(mk(1'b1, 32'h0000_0030, 32'h0, 1'b1, 1, 15, 32'h55AA_1234,
                    16'h000C, 32'h55AA_1234, 18));
    vt.push_back(mk(1'b1, 32'h0000_0034, 32'h0, 1'b0, 0, 16, 32'h1111_2222,
                    16'h000D, 32'hDEAD_BEEF, 17));
    vt.push_back(mk(1'b1, 32'hFFFF_ABCF, 32'h0, 1'b1, 0, 1, 32'h0000_0001,
                    16'hEAF3, 32'h0000_0001, 3));
    vt.push_back(mk(1'b0, 32'h0003_FFFC, 32'hFFFF_FFFF, 1'b1, 2, 1, 32'h0,
                    16'hFFFF, 32'h0, NP ? 5 : 4));
    foreach (vt[i]) run_vec(vt[i], i);

    hold_test();
    reset_test();
    run_vec(mk(1'b1, 32'h0000_0060, 32'h0, 1'b1, 0, 2, 32'h600D_0001,
               16'h0018, 32'h600D_0001, 4), 100);

    // Randomized transactions against the reference model
    for (int i = 0; i < 24; i++) begin
      v.wen   = 1'($urandom);
      v.add   = $urandom;
      v.data  = $urandom;
      v.id    = ID_W'($urandom);
      v.stall = $urandom_range(0, 3);
      v.rdata = $urandom;
      if (v.wen) v.delay = ($urandom_range(0, 4) == 0) ? NO_RSP : $urandom_range(1, 20);
      else       v.delay = $urandom_range(1, 6);
      v = model(v);
      run_vec(v, 200 + i);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
